id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register that sits directly downstream of the register file. Captures the operands read from the register file, together with the decoded controls, for the EX stage.
- Detects load-use hazards and generates a one-cycle stall plus bubble.
- Bypasses a same-cycle writeback, because a register-file write lands only at the clock edge.
- Honours a branch flush and counts inserted bubbles.

Parameters:
- DATA_WIDTH, 16, operand/immediate width
- REG_ADDR_WIDTH, 3, register index width (8 registers; r0 hardwired zero)
- CNT_WIDTH, 16, bubble counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_Valid  in  1  IF/ID holds a real instruction
- i_A  in  DATA_WIDTH  register-file read data for Rs
- i_B  in  DATA_WIDTH  register-file read data for Rt
- i_Rs, i_Rt, i_Rd  in  REG_ADDR_WIDTH  decoded register fields
- i_Uses_Rs, i_Uses_Rt  in  1  instruction actually reads Rs/Rt
- i_Imm  in  DATA_WIDTH  sign-extended immediate
- i_RegWrite, i_MemRead, i_MemWrite, i_ALUSrc, i_RegDst  in  1  decoded controls
- i_ALUOp  in  3  ALU operation
- i_WB_RegWrite  in  1  writeback write enable (same signal that drives the register-file write)
- i_WB_Register  in  REG_ADDR_WIDTH  writeback target
- i_WB_Data  in  DATA_WIDTH  writeback data
- i_Flush  in  1  branch taken in EX; ID instruction is wrong-path
- o_Stall  out  1  combinational; hold PC and IF/ID this cycle
- o_Valid  out  1  EX slot holds a real instruction
- o_A, o_B, o_Imm  out  DATA_WIDTH  registered operands/immediate
- o_Rs, o_Rt  out  REG_ADDR_WIDTH  registered source indices (for EX forwarding)
- o_Dest  out  REG_ADDR_WIDTH  registered destination = RegDst ? Rd : Rt
- o_RegWrite, o_MemRead, o_MemWrite, o_ALUSrc  out  1  registered controls
- o_ALUOp  out  3  registered ALU operation
- o_Bubble_Count  out  CNT_WIDTH  bubbles inserted since reset

Behaviour:
- Reset: every registered output is 0, including o_Valid and o_Bubble_Count. o_Stall is 0 while rst=1. rst has priority over all other inputs, including mid-stall.
- Load-use hazard (combinational): hz = o_Valid & o_MemRead & (o_Dest != 0) & ((i_Uses_Rs & i_Rs == o_Dest) | (i_Uses_Rt & i_Rt == o_Dest)) & i_Valid.
- o_Stall = hz & ~i_Flush & ~rst.
- Per clock edge, in priority order:
  1. rst: clear all.
  2. i_Flush: load a bubble and increment the counter.
  3. hz: load a bubble and increment the counter.
  4. ~i_Valid: load a bubble; counter unchanged.
  5. Otherwise: load the instruction.
- Bubble: o_Valid, o_RegWrite, o_MemRead and o_MemWrite = 0. Data, index and ALU fields are don't-care and are zeroed.
- Load: o_Valid = 1 and controls are copied. o_Dest = i_RegDst ? i_Rd : i_Rt.
- A-operand bypass on load: o_A = i_WB_Data if i_WB_RegWrite & (i_WB_Register != 0) & (i_WB_Register == i_Rs); otherwise o_A = i_A.
- B-operand bypass: same rule against i_Rt, selecting i_WB_Data or i_B.
- Register 0 is never bypassed and reads as i_A/i_B, which the register file holds at 0.
- A stall lasts exactly one cycle: the bubble clears o_MemRead, so hz drops on the next cycle and the held IF/ID instruction then loads.
- Stall and flush in the same cycle: the flush wins, o_Stall = 0, and one bubble is counted.
- o_Bubble_Count saturates at all-ones and does not wrap.
- Latency: 1 cycle from ID inputs to registered outputs.
- No internal state other than the pipeline register and the counter.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> all outputs 0, o_Stall = 0, o_Bubble_Count = 0.
- Plain load: i_Valid=1, i_Rs=1, i_Rt=2, i_A=0x1234, i_B=0x00FF, i_RegDst=1, i_Rd=3, i_ALUOp=2 -> next cycle o_Valid=1, o_A=0x1234, o_B=0x00FF, o_Dest=3, o_ALUOp=2, o_Stall=0.
- Load-use: the EX slot holds a load (MemRead=1, o_Dest=4), and ID has i_Rs=4, i_Uses_Rs=1 ->
  - o_Stall=1 for exactly one cycle.
  - A bubble is inserted (o_Valid=0) and o_Bubble_Count=1.
  - The next cycle loads the held instruction with o_Stall=0.
- Hazard to r0: EX load with o_Dest=0 and ID i_Rs=0 -> o_Stall=0, no bubble.
- WB bypass: i_WB_RegWrite=1, i_WB_Register=5, i_WB_Data=0xBEEF, i_Rt=5, i_B=0x0000 -> o_B=0xBEEF. Repeat with i_WB_Register=0 and i_Rt=0 -> o_B=i_B.
- Flush vs stall: hazard condition and i_Flush=1 in the same cycle -> o_Stall=0, one bubble, counter +1. Preload the counter near 0xFFFF and force bubbles -> it holds at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register with load-use stall, WB bypass, flush
//             and saturating bubble counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_Valid,
    input  logic [DATA_WIDTH-1:0]     i_A,
    input  logic [DATA_WIDTH-1:0]     i_B,
    input  logic [REG_ADDR_WIDTH-1:0] i_Rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_Rt,
    input  logic [REG_ADDR_WIDTH-1:0] i_Rd,
    input  logic                      i_Uses_Rs,
    input  logic                      i_Uses_Rt,
    input  logic [DATA_WIDTH-1:0]     i_Imm,
    input  logic                      i_RegWrite,
    input  logic                      i_MemRead,
    input  logic                      i_MemWrite,
    input  logic                      i_ALUSrc,
    input  logic                      i_RegDst,
    input  logic [2:0]                i_ALUOp,
    input  logic                      i_WB_RegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] i_WB_Register,
    input  logic [DATA_WIDTH-1:0]     i_WB_Data,
    input  logic                      i_Flush,
    output logic                      o_Stall,
    output logic                      o_Valid,
    output logic [DATA_WIDTH-1:0]     o_A,
    output logic [DATA_WIDTH-1:0]     o_B,
    output logic [DATA_WIDTH-1:0]     o_Imm,
    output logic [REG_ADDR_WIDTH-1:0] o_Rs,
    output logic [REG_ADDR_WIDTH-1:0] o_Rt,
    output logic [REG_ADDR_WIDTH-1:0] o_Dest,
    output logic                      o_RegWrite,
    output logic                      o_MemRead,
    output logic                      o_MemWrite,
    output logic                      o_ALUSrc,
    output logic [2:0]                o_ALUOp,
    output logic [CNT_WIDTH-1:0]      o_Bubble_Count
);

    localparam logic [CNT_WIDTH-1:0]      c_CNT_MAX = '1;
    localparam logic [REG_ADDR_WIDTH-1:0] c_R0      = '0;

    logic                      r_valid;
    logic [DATA_WIDTH-1:0]     r_a;
    logic [DATA_WIDTH-1:0]     r_b;
    logic [DATA_WIDTH-1:0]     r_imm;
    logic [REG_ADDR_WIDTH-1:0] r_rs;
    logic [REG_ADDR_WIDTH-1:0] r_rt;
    logic [REG_ADDR_WIDTH-1:0] r_dest;
    logic                      r_regwrite;
    logic                      r_memread;
    logic                      r_memwrite;
    logic                      r_alusrc;
    logic [2:0]                r_aluop;
    logic [CNT_WIDTH-1:0]      r_bubble_cnt;

    logic                      w_hz;
    logic                      w_bubble;
    logic                      w_count;
    logic                      w_byp_a;
    logic                      w_byp_b;
    logic [DATA_WIDTH-1:0]     w_a;
    logic [DATA_WIDTH-1:0]     w_b;
    logic [REG_ADDR_WIDTH-1:0] w_dest;
    logic [CNT_WIDTH-1:0]      w_cnt_next;

    // Load in EX whose destination is read by the instruction in ID.
    assign w_hz = r_valid & r_memread & (r_dest != c_R0) & i_Valid &
                  ((i_Uses_Rs & (i_Rs == r_dest)) | (i_Uses_Rt & (i_Rt == r_dest)));

    assign o_Stall = w_hz & ~i_Flush & ~rst;

    assign w_count  = i_Flush | w_hz;
    assign w_bubble = w_count | ~i_Valid;

    // The register file only commits at the edge, so a same-cycle write is forwarded here.
    assign w_byp_a = i_WB_RegWrite & (i_WB_Register != c_R0) & (i_WB_Register == i_Rs);
    assign w_byp_b = i_WB_RegWrite & (i_WB_Register != c_R0) & (i_WB_Register == i_Rt);
    assign w_a     = w_byp_a ? i_WB_Data : i_A;
    assign w_b     = w_byp_b ? i_WB_Data : i_B;
    assign w_dest  = i_RegDst ? i_Rd : i_Rt;

    assign w_cnt_next = (r_bubble_cnt == c_CNT_MAX) ? r_bubble_cnt : r_bubble_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_valid    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_dest     <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_aluop    <= '0;
        end else begin
            r_valid    <= 1'b1;
            r_a        <= w_a;
            r_b        <= w_b;
            r_imm      <= i_Imm;
            r_rs       <= i_Rs;
            r_rt       <= i_Rt;
            r_dest     <= w_dest;
            r_regwrite <= i_RegWrite;
            r_memread  <= i_MemRead;
            r_memwrite <= i_MemWrite;
            r_alusrc   <= i_ALUSrc;
            r_aluop    <= i_ALUOp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (w_count) begin
            r_bubble_cnt <= w_cnt_next;
        end
    end

    assign o_Valid        = r_valid;
    assign o_A            = r_a;
    assign o_B            = r_b;
    assign o_Imm          = r_imm;
    assign o_Rs           = r_rs;
    assign o_Rt           = r_rt;
    assign o_Dest         = r_dest;
    assign o_RegWrite     = r_regwrite;
    assign o_MemRead      = r_memread;
    assign o_MemWrite     = r_memwrite;
    assign o_ALUSrc       = r_alusrc;
    assign o_ALUOp        = r_aluop;
    assign o_Bubble_Count = r_bubble_cnt;

endmodule

`default_nettype wire
